// File: rtl/q_div_pkg.sv
// Shared constants and types for the sequential sign-magnitude Q-format divider.
package q_div_pkg;

    localparam int unsigned N_DEFAULT = 32;
    localparam int unsigned Q_DEFAULT = 15;

    // One restoring step per bit of (|dividend| << Q), which is N-1+Q bits wide.
    function automatic int unsigned calc_iter(input int unsigned n, input int unsigned q);
        return n + q - 1;
    endfunction

    localparam int unsigned ITER_DEFAULT = calc_iter(N_DEFAULT, Q_DEFAULT);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

endpackage

// File: rtl/q_div_step.sv
// One restoring division step: shift in a dividend bit, subtract the divisor if it fits.
module q_div_step #(
    parameter int unsigned RW = 47,
    parameter int unsigned MW = 31
) (
    input  logic [RW-1:0] rem_i,
    input  logic          bit_i,
    input  logic [MW-1:0] divisor_i,
    output logic [RW-1:0] rem_o,
    output logic          q_bit_o
);

    logic [RW:0]   shifted;
    logic [RW:0]   div_ext;
    logic [RW-1:0] diff;

    // Compare the shifted remainder against the divisor and restore when it does not fit.
    always_comb begin
        // NOTE: blocking '=' here so each line sees the values computed just above it.
        shifted = {rem_i, bit_i};
        div_ext = {{(RW + 1 - MW){1'b0}}, divisor_i};
        diff    = shifted[RW-1:0] - div_ext[RW-1:0];
        q_bit_o = (shifted >= div_ext);
        rem_o   = q_bit_o ? diff : shifted[RW-1:0];
    end

endmodule

// File: rtl/q_div.sv
// Sequential sign-magnitude Q-format divider, one quotient bit per clock.
module q_div
    import q_div_pkg::*;
#(
    parameter int unsigned Q = Q_DEFAULT,
    parameter int unsigned N = N_DEFAULT
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic [N-1:0] i_dividend,
    input  logic [N-1:0] i_divisor,
    input  logic         i_start,
    output logic [N-1:0] o_quotient_out,
    output logic         o_complete,
    output logic         o_overflow
);

    localparam int unsigned ITER = calc_iter(N, Q);
    localparam int unsigned MW   = N - 1;          // operand magnitude width
    localparam int unsigned QW   = N - 1 + Q;      // full quotient width
    localparam int unsigned RW   = QW + 1;         // remainder width
    localparam int unsigned CW   = $clog2(ITER + 1);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q,   cnt_d;
    logic [RW-1:0] rem_q,   rem_d;
    logic [QW-1:0] dvd_q,   dvd_d;
    logic [QW-1:0] quo_q,   quo_d;
    logic [MW-1:0] dsr_q,   dsr_d;
    logic          sign_q,  sign_d;
    logic [N-1:0]  quot_q,  quot_d;
    logic          cmp_q,   cmp_d;
    logic          ovf_q,   ovf_d;

    logic [RW-1:0] step_rem;
    logic          q_bit;
    logic [MW-1:0] mag_low;
    logic          ovf_fin;
    logic [MW-1:0] mag_fin;

    q_div_step #(
        .RW (RW),
        .MW (MW)
    ) u_step (
        .rem_i     (rem_q),
        .bit_i     (dvd_q[QW-1]),
        .divisor_i (dsr_q),
        .rem_o     (step_rem),
        .q_bit_o   (q_bit)
    );

    // Next-state and datapath control: capture on start, step while busy, publish on the last step.
    always_comb begin
        // NOTE: every _d defaults to its _q first so no branch can leave a latch behind.
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        dvd_d   = dvd_q;
        quo_d   = quo_q;
        dsr_d   = dsr_q;
        sign_d  = sign_q;
        quot_d  = quot_q;
        cmp_d   = cmp_q;
        ovf_d   = ovf_q;

        // On the final step quo_q still sits one place below its final position,
        // so quotient bits at or above N-1 are quo_q[QW-1:MW-1].
        mag_low = {quo_q[MW-2:0], q_bit};
        ovf_fin = (|quo_q[QW-1:MW-1]) | (dsr_q == '0);
        mag_fin = ovf_fin ? {MW{1'b1}} : mag_low;

        unique case (state_q)
            IDLE: begin
                if (i_start) begin
                    state_d = BUSY;
                    cnt_d   = CW'(ITER);
                    rem_d   = '0;
                    quo_d   = '0;
                    dvd_d   = QW'(i_dividend[N-2:0]) << Q;
                    dsr_d   = i_divisor[N-2:0];
                    sign_d  = i_dividend[N-1] ^ i_divisor[N-1];
                    cmp_d   = 1'b0;
                end
            end
            BUSY: begin
                rem_d = step_rem;
                dvd_d = dvd_q << 1;
                quo_d = {quo_q[QW-2:0], q_bit};
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CW'(1)) begin
                    state_d = IDLE;
                    cmp_d   = 1'b1;
                    ovf_d   = ovf_fin;
                    // A zero magnitude never carries a negative sign.
                    quot_d  = {sign_q & (|mag_fin), mag_fin};
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with asynchronous abort.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            // NOTE: the datapath is reset too, so an aborted divide leaves nothing stale behind.
            state_q <= IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            dvd_q   <= '0;
            quo_q   <= '0;
            dsr_q   <= '0;
            sign_q  <= 1'b0;
            quot_q  <= '0;
            cmp_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            // NOTE: '<=' so every register samples values from before this edge.
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            dvd_q   <= dvd_d;
            quo_q   <= quo_d;
            dsr_q   <= dsr_d;
            sign_q  <= sign_d;
            quot_q  <= quot_d;
            cmp_q   <= cmp_d;
            ovf_q   <= ovf_d;
        end
    end

    assign o_quotient_out = quot_q;
    assign o_complete     = cmp_q;
    assign o_overflow     = ovf_q;

endmodule

// File: tb/tb_q_div.sv
// Self-checking bench for q_div: arithmetic reference model plus directed vectors.
module tb_q_div;

    localparam int N    = 32;
    localparam int Q    = 15;
    localparam int ITER = 46;

    logic          clk;
    logic          rst;
    logic [N-1:0]  dividend;
    logic [N-1:0]  divisor;
    logic          start;
    logic [N-1:0]  quot;
    logic          complete;
    logic          ovf;

    int tests_run    = 0;
    int tests_failed = 0;
    bit chk_en       = 1'b0;

    q_div #(
        .Q (Q),
        .N (N)
    ) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_dividend     (dividend),
        .i_divisor      (divisor),
        .i_start        (start),
        .o_quotient_out (quot),
        .o_complete     (complete),
        .o_overflow     (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference result {overflow, sign, magnitude} from plain integer arithmetic.
    function automatic logic [32:0] ref_div(input logic [31:0] a, input logic [31:0] b);
        longint unsigned ma, mb, m;
        logic            o;
        logic [30:0]     mo;
        logic            s;
        ma = 64'(a[30:0]);
        mb = 64'(b[30:0]);
        m  = 0;
        if (mb == 0) begin
            o = 1'b1;
        end else begin
            m = (ma << Q) / mb;
            o = (m >= (64'd1 << (N - 1)));
        end
        mo = o ? 31'h7FFF_FFFF : m[30:0];
        s  = (a[31] ^ b[31]) & (mo != 0);
        return {o, s, mo};
    endfunction

    // Transaction-level model: result captured when a start is accepted, published ITER edges later.
    logic [32:0] m_res;
    int          m_cnt;
    bit          m_busy;
    logic [31:0] exp_q;
    logic        exp_ovf;
    logic        exp_cmp;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy  <= 1'b0;
            m_cnt   <= 0;
            m_res   <= '0;
            exp_q   <= '0;
            exp_ovf <= 1'b0;
            exp_cmp <= 1'b0;
        end else if (!m_busy) begin
            if (start) begin
                m_busy  <= 1'b1;
                m_cnt   <= ITER;
                m_res   <= ref_div(dividend, divisor);
                exp_cmp <= 1'b0;
            end
        end else begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 1) begin
                m_busy  <= 1'b0;
                exp_cmp <= 1'b1;
                exp_ovf <= m_res[32];
                exp_q   <= m_res[31:0];
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                check("cyc_quot",     64'(quot),     64'(exp_q));
                check("cyc_overflow", 64'(ovf),      64'(exp_ovf));
                check("cyc_complete", 64'(complete), 64'(exp_cmp));
            end
        end
    end

    // One directed divide: pins the model to a hand value, then checks latency and result.
    task automatic run_div(input string name, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] eq, input logic eo);
        logic [32:0] r;
        int          lat;
        bit          done;
        r = ref_div(a, b);
        check({name, "_model"}, 64'(r), 64'({eo, eq}));
        @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat   = 0;
        done  = 1'b0;
        for (int c = 1; c <= 60 && !done; c++) begin
            @(negedge clk);
            if (complete) begin
                done = 1'b1;
                lat  = c;
            end
        end
        check({name, "_latency"},  64'(lat),  64'(ITER));
        check({name, "_quot"},     64'(quot), 64'(eq));
        check({name, "_overflow"}, 64'(ovf),  64'(eo));
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] d;
        logic [32:0] r;

        rst      = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (3) @(negedge clk);
        check("rst_quot",     64'(quot),     64'(0));
        check("rst_complete", 64'(complete), 64'(0));
        check("rst_overflow", 64'(ovf),      64'(0));
        rst    = 1'b0;
        chk_en = 1'b1;

        // Directed vectors with hand-computed results.
        run_div("3_div_2",      32'h0001_8000, 32'h0001_0000, 32'h0000_C000, 1'b0);
        run_div("m2_div_1",     32'h8001_0000, 32'h0000_8000, 32'h8001_0000, 1'b0);
        run_div("m2_div_m1",    32'h8001_0000, 32'h8000_8000, 32'h0001_0000, 1'b0);
        run_div("lsb_div_lsb",  32'h0000_0001, 32'h0000_0001, 32'h0000_8000, 1'b0);
        run_div("trunc_zero",   32'h0000_0001, 32'h0001_0000, 32'h0000_0000, 1'b0);
        run_div("neg_zero",     32'h8000_0001, 32'h0001_0000, 32'h0000_0000, 1'b0);
        run_div("third",        32'h0000_8000, 32'h0001_8000, 32'h0000_2AAA, 1'b0);
        run_div("max_fit",      32'h7FFF_FFFF, 32'h0001_0000, 32'h3FFF_FFFF, 1'b0);
        run_div("ovf_edge",     32'h4000_0000, 32'h0000_4000, 32'h7FFF_FFFF, 1'b1);
        run_div("ovf_big",      32'h7FFF_FFFF, 32'h0000_0001, 32'h7FFF_FFFF, 1'b1);
        run_div("div_zero",     32'h0001_8000, 32'h0000_0000, 32'h7FFF_FFFF, 1'b1);
        run_div("div_negzero",  32'h0001_8000, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);

        // Sweep: start every 48 cycles, operands scrambled and start re-pulsed mid-divide.
        a = 32'h4000_1235;
        d = 32'h0000_0101;
        for (int k = 0; k < 20; k++) begin
            r = ref_div(a, d);
            @(negedge clk);
            dividend = a;
            divisor  = d;
            start    = 1'b1;
            @(negedge clk);
            start = 1'b0;
            repeat (10) @(negedge clk);
            dividend = $urandom;
            divisor  = $urandom;
            start    = 1'b1;
            @(negedge clk);
            start = 1'b0;
            repeat (35) @(negedge clk);
            check("sweep_complete", 64'(complete), 64'(1));
            check("sweep_result",   64'({ovf, quot}), 64'(r));
            a = (a << 1) + 32'd3;
            d = (d << 1) + 32'd1;
        end

        // Start held high: back-to-back divides, each checked by the per-cycle compare.
        @(negedge clk);
        dividend = 32'h0001_8000;
        divisor  = 32'h0001_0000;
        start    = 1'b1;
        repeat (150) @(negedge clk);
        start = 1'b0;
        repeat (50) @(negedge clk);
        check("held_complete", 64'(complete), 64'(1));
        check("held_quot",     64'(quot),     64'(32'h0000_C000));

        // Abort at cycle 20 of a divide, then a fresh divide must run normally.
        @(negedge clk);
        dividend = 32'h7FFF_FFFF;
        divisor  = 32'h0000_0001;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);
        check("pre_abort_quot",     64'(quot),     64'(32'h0000_C000));
        check("pre_abort_complete", 64'(complete), 64'(0));
        #2 rst = 1'b1;
        #1;
        check("abort_quot",     64'(quot),     64'(0));
        check("abort_overflow", 64'(ovf),      64'(0));
        check("abort_complete", 64'(complete), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        run_div("after_abort", 32'h0001_8000, 32'h0001_0000, 32'h0000_C000, 1'b0);

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // Run-time bound so the bench always terminates.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/q_div.md
# q_div

Sequential fixed-point divider for sign-magnitude Q-format operands. It computes `dividend / divisor` by restoring shift-subtract, producing one quotient bit per clock. It reports completion and overflow, and serves as a shared arithmetic unit wherever a multi-cycle divide is acceptable.

## Interface
Parameters:
- `Q`, default 15: number of fractional bits.
- `N`, default 32: total word width, including the sign bit.

Ports:
- `i_clk`, input, 1: clock. All state changes on its rising edge.
- `i_rst`, input, 1: reset. Asynchronous, active-high.
- `i_dividend`, input, N: sign-magnitude. Bit N-1 is the sign; bits N-2:0 are the magnitude with Q fractional bits.
- `i_divisor`, input, N: same format as `i_dividend`.
- `i_start`, input, 1: start request. Sampled on a rising edge while idle.
- `o_quotient_out`, output, N: sign-magnitude result, same format as the operands.
- `o_complete`, output, 1: high when the result is valid. Held until the next accepted start.
- `o_overflow`, output, 1: the result magnitude does not fit in N-1 bits, or the divisor is zero.

## Operation
- Two states, IDLE and BUSY. Reset enters IDLE.
- IDLE, `i_start`=1 at a rising edge:
  - Capture both operands.
  - Clear `o_complete`.
  - Load the iteration counter with ITER = N+Q-1 (46 by default).
  - Enter BUSY.
- BUSY:
  - `i_start` is ignored; operand changes have no effect.
  - Each cycle performs one restoring step on the magnitudes:
    - remainder = (remainder << 1) | next bit of (|dividend| << Q), MSB first;
    - if remainder ≥ |divisor|, subtract and shift in quotient bit 1, else shift in 0;
    - decrement the counter.
  - After ITER steps, the mathematical magnitude is floor((|a|·2^Q)/|b|), an (N-1+Q)-bit value.
- Completion, on the edge that finishes the last step:
  - `o_overflow` = 1 if any magnitude bit at or above position N-1 is set.
  - `o_quotient_out[N-2:0]` = low N-1 magnitude bits. When overflowing, saturate to all ones instead.
  - `o_quotient_out[N-1]` = sign(a) XOR sign(b). Forced to 0 when the output magnitude is 0.
  - `o_complete` set to 1; return to IDLE.
- Divisor magnitude 0:
  - Runs the full ITER cycles with no early exit.
  - Result magnitude is all ones, `o_overflow`=1, sign as above.
- Between completions, `o_quotient_out` and `o_overflow` hold the previous result. They update only at completion.
- Truncation is toward zero on the magnitude. There is no rounding.

## Timing
- Reset values:
  - `o_quotient_out`=0, `o_complete`=0, `o_overflow`=0;
  - state IDLE, counter 0, internal registers 0.
- Latency:
  - call the edge that accepts `i_start` edge 0;
  - `o_complete` rises after edge ITER (46 by default) and stays high until the next accepted start.
  - A new start may be accepted on the first edge where the block is IDLE, i.e. edge ITER+1 (the cycle after `o_complete` rises). This gives a back-to-back throughput of ITER+1 = 47 cycles per divide.
- `i_start` held high continuously: a new divide starts on each edge where the block is IDLE.
- Asserting `i_rst` mid-operation aborts immediately. All outputs return to their reset values; the next start behaves normally.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Shared package `q_div_pkg`:
  - defaults for `N` and `Q`;
  - derived constant ITER = N+Q-1;
  - state enum {IDLE, BUSY}.
- Single module `q_div`:
  - Datapath: remainder register (N-1+Q+1 bits), shifting dividend register, quotient register (N-1+Q bits), divisor-magnitude register, sign register, counter of clog2(ITER+1) bits.
  - No sub-module is required. An optional `q_div_step` (one combinational compare/subtract/shift) is acceptable.

## Test plan
- Operands 0x00018000 (3.0) / 0x00010000 (2.0), pulse start -> after 46 cycles `o_complete`=1, quotient 0x0000C000 (1.5), overflow 0.
- Operands 0x80010000 (-2.0) / 0x00008000 (1.0) -> quotient 0x80010000, overflow 0. Also 0x80010000 / 0x80008000 -> 0x00010000.
- Operands 0x00000001 / 0x00000001 -> quotient 0x00008000 (1.0). Operands 0x00000001 / 0x00010000 -> 0x00000000 (truncated, sign bit 0).
- Operands 0x7FFFFFFF / 0x00000001 -> `o_overflow`=1, quotient 0x7FFFFFFF. Divisor 0x00000000 or 0x80000000 -> overflow 1, magnitude all ones.
- Start pulsed every 48 cycles while sweeping the divisor as (d<<1)+1 and the dividend as (a<<1)+3 -> every result matches a reference model; operand changes during BUSY do not affect the result.
- Assert `i_rst` at cycle 20 of a divide -> outputs go to 0 immediately; a subsequent start completes correctly after 46 cycles.
